pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates every stall, flush, kill and freeze enable from four sources: load-use hazards, control redirects resolved in MEM, instruction/data memory wait-states, and debug halt/single-step requests.
- Holds a small run-control FSM, a memory-timeout watchdog and saturating performance counters.
- Sits in the CPU top level beside the datapath and drives the pipeline-register control pins directly.

Parameters:
- CNT_W, 32, width of each performance counter
- TIMEOUT_W, 8, width of the memory-wait watchdog counter
- MEM_TIMEOUT, 255, consecutive dmem wait cycles before the ERROR state; must be < 2^TIMEOUT_W

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_mem_read  in  1  MemRead from ID/EX outputs
- ex_rd  in  5  rd from ID/EX outputs
- mem_redirect  in  1  EX/MEM branch_taken or Jump
- imem_ready  in  1  instruction fetch data valid this cycle
- dmem_req  in  1  MEM-stage MemRead or MemWrite
- dmem_ready  in  1  data memory completes this cycle
- dbg_halt_req  in  1  request halt (level)
- dbg_step  in  1  single-step pulse while halted
- dbg_resume  in  1  resume pulse while halted
- pc_en  out  1  PC register update enable
- pc_sel  out  1  1 = PC loads the EX/MEM branch target
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  NOP into IF/ID
- id_ex_flush  out  1  bubble into ID/EX
- ex_kill  out  1  zero RegWrite/MemWrite/MemRead entering EX/MEM
- back_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB and IF/ID
- halted  out  1  FSM in HALT
- mem_timeout_err  out  1  sticky watchdog error
- perf_load_use  out  CNT_W  load-use stall cycles
- perf_flush  out  CNT_W  redirect flush events
- perf_mem_wait  out  CNT_W  dmem wait cycles

Behaviour:
- **Timing:**
  - FSM, watchdog, halt_pending and counters are registered.
  - Control outputs are combinational from state and current inputs, with zero latency.
- **Reset:**
  - State = RUN; counters, watchdog, halt_pending and mem_timeout_err = 0.
  - While reset is high, all control outputs = 0.
- **Definitions:**
  - load_use = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
  - dwait = dmem_req & ~dmem_ready.
- **States:** RUN, MEM_WAIT, HALT, STEP, ERROR.
- **RUN / STEP, per-cycle priority (first match wins; unlisted outputs 0):**
  1. dwait: back_freeze=1, if_id_stall=1, pc_en=0; next state = MEM_WAIT.
  2. mem_redirect: pc_en=1, pc_sel=1, if_id_flush=1, id_ex_flush=1, ex_kill=1; perf_flush += 1. A coincident load_use is discarded.
  3. load_use: pc_en=0, if_id_stall=1, id_ex_flush=1; perf_load_use += 1.
  4. ~imem_ready: pc_en=0, if_id_flush=1.
  5. Otherwise: pc_en=1.
- **MEM_WAIT:**
  - Outputs as rule 1; perf_mem_wait += 1; watchdog += 1.
  - dmem_ready=1: outputs are evaluated as in RUN for that same cycle (freeze released), watchdog clears, next state = RUN (or STEP's return target, see below).
  - Watchdog reaches MEM_TIMEOUT with dmem_ready=0: next state = ERROR.
- **ERROR:** back_freeze=1, if_id_stall=1, pc_en=0, mem_timeout_err=1. Exits only through reset.
- **Halt entry:**
  - dbg_halt_req in RUN with no dwait: next state = HALT.
  - dbg_halt_req seen in MEM_WAIT: sets halt_pending; HALT is entered on the first RUN cycle without dwait.
- **HALT:**
  - Outputs: pc_en=0, if_id_stall=1, id_ex_flush=1, halted=1. The back end drains as bubbles.
  - dbg_resume: next state = RUN.
  - dbg_step (without resume): next state = STEP. Resume wins if both arrive together.
- **STEP:**
  - Exactly one cycle of RUN behaviour, then back to HALT.
  - If that cycle is dwait, the FSM goes through MEM_WAIT and returns to HALT on dmem_ready.
- **Counters:** saturate at all-ones; they never wrap.
- **Reset mid-operation:** reset mid-MEM_WAIT or mid-ERROR returns to RUN immediately and asynchronously.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - typedef ctrl_state_e for {RUN, MEM_WAIT, HALT, STEP, ERROR};
  - the NOP encoding 32'h00000013;
  - the default CNT_W.
- One sub-module, sat_counter (parameter W; inputs inc and clr; saturating), instantiated three times.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle -> pc_en=0, if_id_stall=1, id_ex_flush=1; perf_load_use=1.
- Hazard on x0: same stimulus with ex_rd=0 and id_rs1=0 -> no stall, pc_en=1.
- Redirect vs load-use: mem_redirect=1 while the load_use condition holds -> pc_sel=1, if_id_flush=id_ex_flush=ex_kill=1, if_id_stall=0; perf_flush=1, perf_load_use=0.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> back_freeze=1 for 3 cycles and 0 on the ready cycle; perf_mem_wait=3.
- Watchdog: MEM_TIMEOUT=4, dmem_ready held 0 -> ERROR after the 4th wait cycle; mem_timeout_err stays 1 until reset pulses, then returns to 0 with state RUN.
- Debug: halt_req asserted -> halted=1 next cycle; dbg_step pulse -> exactly one pc_en=1 cycle, then halted=1; dbg_step and dbg_resume together -> RUN.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// cpu_ctrl_pkg
// Shared run-control state encoding and constants for the CPU control blocks.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEM_WAIT = 3'd1,
    HALT     = 3'd2,
    STEP     = 3'd3,
    ERROR    = 3'd4
  } ctrl_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] c_nop_insn      = 32'h0000_0013;
  localparam int          c_cnt_w_default = 32;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter
// Up counter that sticks at all-ones instead of wrapping; synchronous clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
// ============================================================================
// pipeline_hazard_controller
// Stall/flush/freeze sequencing for the 5-stage pipeline with debug run control.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W       = c_cnt_w_default,
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_redirect,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             dbg_halt_req,
  input  logic             dbg_step,
  input  logic             dbg_resume,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_kill,
  output logic             back_freeze,
  output logic             halted,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] perf_load_use,
  output logic [CNT_W-1:0] perf_flush,
  output logic [CNT_W-1:0] perf_mem_wait
);

  localparam logic [TIMEOUT_W-1:0] c_timeout = TIMEOUT_W'(MEM_TIMEOUT);

  ctrl_state_e          r_state, w_next;
  logic [TIMEOUT_W-1:0] r_wd, w_wd_next, w_wd_inc;
  logic                 r_halt_pending, w_pend_next;
  logic                 r_ret_halt, w_ret_next;
  logic                 w_load_use, w_dwait, w_run_eval;
  logic                 w_inc_lu, w_inc_fl, w_inc_mw;

  assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));
  assign w_dwait    = dmem_req && !dmem_ready;
  assign w_wd_inc   = r_wd + TIMEOUT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= RUN;
      r_wd           <= '0;
      r_halt_pending <= 1'b0;
      r_ret_halt     <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_wd           <= w_wd_next;
      r_halt_pending <= w_pend_next;
      r_ret_halt     <= w_ret_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_wd_next   = r_wd;
    w_pend_next = r_halt_pending;
    w_ret_next  = r_ret_halt;
    w_run_eval  = 1'b0;
    w_inc_lu    = 1'b0;
    w_inc_fl    = 1'b0;
    w_inc_mw    = 1'b0;
    pc_en       = 1'b0;
    pc_sel      = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_kill     = 1'b0;
    back_freeze = 1'b0;

    case (r_state)
      RUN, STEP: w_run_eval = 1'b1;
      MEM_WAIT: begin
        if (dbg_halt_req) w_pend_next = 1'b1;
        if (w_dwait) begin
          back_freeze = 1'b1;
          if_id_stall = 1'b1;
          w_inc_mw    = 1'b1;
          w_wd_next   = w_wd_inc;
          if (w_wd_inc >= c_timeout) w_next = ERROR;
        end else begin
          // Memory completed: this cycle behaves as RUN with the freeze released.
          w_run_eval = 1'b1;
          w_wd_next  = '0;
          w_ret_next = 1'b0;
          w_next     = r_ret_halt ? HALT : RUN;
        end
      end
      HALT: begin
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
        if (dbg_resume)    w_next = RUN;
        else if (dbg_step) w_next = STEP;
      end
      ERROR: begin
        back_freeze = 1'b1;
        if_id_stall = 1'b1;
      end
      default: w_next = RUN;
    endcase

    if (w_run_eval) begin
      if (w_dwait) begin
        back_freeze = 1'b1;
        if_id_stall = 1'b1;
        w_inc_mw    = 1'b1;
        w_wd_next   = w_wd_inc;
        w_next      = MEM_WAIT;
        w_ret_next  = (r_state == STEP);
        if (dbg_halt_req && (r_state == RUN)) w_pend_next = 1'b1;
      end else begin
        w_wd_next = '0;
        if (mem_redirect) begin
          pc_en       = 1'b1;
          pc_sel      = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          ex_kill     = 1'b1;
          w_inc_fl    = 1'b1;
        end else if (w_load_use) begin
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          w_inc_lu    = 1'b1;
        end else if (!imem_ready) begin
          if_id_flush = 1'b1;
        end else begin
          pc_en = 1'b1;
        end
        if (r_state == STEP) begin
          w_next = HALT;
        end else if ((r_state == RUN) && (dbg_halt_req || r_halt_pending)) begin
          w_next = HALT;
        end
      end
    end

    if (w_next == HALT) w_pend_next = 1'b0;

    if (reset) begin
      pc_en       = 1'b0;
      pc_sel      = 1'b0;
      if_id_stall = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      ex_kill     = 1'b0;
      back_freeze = 1'b0;
    end
  end

  assign halted          = (r_state == HALT)  && !reset;
  assign mem_timeout_err = (r_state == ERROR) && !reset;

  sat_counter #(.W(CNT_W)) u_cnt_load_use (
    .clk(clk), .reset(reset), .inc(w_inc_lu), .clr(1'b0), .count(perf_load_use)
  );

  sat_counter #(.W(CNT_W)) u_cnt_flush (
    .clk(clk), .reset(reset), .inc(w_inc_fl), .clr(1'b0), .count(perf_flush)
  );

  sat_counter #(.W(CNT_W)) u_cnt_mem_wait (
    .clk(clk), .reset(reset), .inc(w_inc_mw), .clr(1'b0), .count(perf_mem_wait)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
// ============================================================================
// tb_pipeline_hazard_controller
// Directed vector table plus hand-written multi-cycle sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_controller;

  localparam int CNT_W = 4;

  // output packing: {pc_en, pc_sel, stall, if_flush, id_flush, kill, freeze, halted}
  localparam logic [7:0] c_idle  = 8'b1000_0000;
  localparam logic [7:0] c_stall = 8'b0010_1000;
  localparam logic [7:0] c_redir = 8'b1101_1100;
  localparam logic [7:0] c_imem  = 8'b0001_0000;
  localparam logic [7:0] c_halt  = 8'b0010_1001;
  localparam logic [7:0] c_frz   = 8'b0010_0010;
  localparam logic [7:0] c_zero  = 8'b0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, mem_redirect, imem_ready;
  logic dmem_req, dmem_ready, dbg_halt_req, dbg_step, dbg_resume;
  logic pc_en, pc_sel, if_id_stall, if_id_flush, id_ex_flush, ex_kill;
  logic back_freeze, halted, mem_timeout_err;
  logic [CNT_W-1:0] perf_load_use, perf_flush, perf_mem_wait;
  logic [7:0] outs;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, redir, iready, dreq, dready;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  assign outs = {pc_en, pc_sel, if_id_stall, if_id_flush, id_ex_flush, ex_kill, back_freeze, halted};

  pipeline_hazard_controller #(.CNT_W(CNT_W), .TIMEOUT_W(8), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_redirect(mem_redirect),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .dbg_halt_req(dbg_halt_req), .dbg_step(dbg_step), .dbg_resume(dbg_resume),
    .pc_en(pc_en), .pc_sel(pc_sel), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_kill(ex_kill), .back_freeze(back_freeze), .halted(halted),
    .mem_timeout_err(mem_timeout_err), .perf_load_use(perf_load_use),
    .perf_flush(perf_flush), .perf_mem_wait(perf_mem_wait)
  );

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                              input logic u2, input logic mr, input logic [4:0] rd,
                              input logic redir, input logic iready, input logic dreq,
                              input logic dready, input logic [7:0] exp, input string name);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.mr = mr; v.rd = rd;
    v.redir = redir; v.iready = iready; v.dreq = dreq; v.dready = dready;
    v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic set_idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_mem_read = 0; mem_redirect = 0; imem_ready = 1; dmem_req = 0; dmem_ready = 0;
    dbg_halt_req = 0; dbg_step = 0; dbg_resume = 0;
  endtask

  task automatic set_dwait(input logic ready);
    dmem_req = 1; dmem_ready = ready;
  endtask

  // check outputs mid-cycle, then advance past the next rising edge
  task automatic cyc(input string nm, input logic [7:0] exp);
    @(negedge clk);
    chk(nm, {24'd0, outs}, {24'd0, exp});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1;
    #1;
    chk("reset_outs", {24'd0, outs}, 32'd0);
    chk("reset_err", {31'd0, mem_timeout_err}, 32'd0);
    @(posedge clk); #1;
    reset = 0;
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_idle,  "idle");
    vecs[1]  = mk(5, 0, 1, 0, 1, 5, 0, 1, 0, 0, c_stall, "lu_rs1");
    vecs[2]  = mk(0, 0, 1, 0, 1, 0, 0, 1, 0, 0, c_idle,  "lu_x0");
    vecs[3]  = mk(3, 7, 1, 1, 1, 7, 0, 1, 0, 0, c_stall, "lu_rs2");
    vecs[4]  = mk(3, 7, 1, 0, 1, 7, 0, 1, 0, 0, c_idle,  "lu_rs2_unused");
    vecs[5]  = mk(5, 0, 1, 0, 0, 5, 0, 1, 0, 0, c_idle,  "no_load");
    vecs[6]  = mk(5, 0, 1, 0, 1, 5, 1, 1, 0, 0, c_redir, "redir_over_lu");
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_imem,  "imem_wait");
    vecs[8]  = mk(9, 0, 1, 0, 1, 9, 0, 0, 0, 0, c_stall, "lu_over_imem");
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, c_redir, "redir_over_imem");
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, c_idle,  "dmem_ready_now");

    set_idle();
    #1;
    chk("reset_hold_outs", {24'd0, outs}, 32'd0);
    @(posedge clk); #1;
    chk("reset_cnt", {20'd0, perf_load_use, perf_flush, perf_mem_wait}, 32'd0);
    reset = 0;

    // single-cycle table, all in RUN
    for (int i = 0; i < 11; i++) begin
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; ex_rd = vecs[i].rd;
      id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2; ex_mem_read = vecs[i].mr;
      mem_redirect = vecs[i].redir; imem_ready = vecs[i].iready;
      dmem_req = vecs[i].dreq; dmem_ready = vecs[i].dready;
      cyc(vecs[i].name, vecs[i].exp);
    end
    set_idle();
    chk("perf_load_use_tbl", {28'd0, perf_load_use}, 32'd3);
    chk("perf_flush_tbl", {28'd0, perf_flush}, 32'd2);
    chk("perf_mem_wait_tbl", {28'd0, perf_mem_wait}, 32'd0);

    // memory wait: 3 wait cycles then ready
    do_reset();
    set_dwait(0);
    for (int i = 0; i < 3; i++) cyc("mw_freeze", c_frz);
    set_dwait(1);
    cyc("mw_release", c_idle);
    set_idle();
    chk("perf_mem_wait", {28'd0, perf_mem_wait}, 32'd3);
    cyc("mw_back_run", c_idle);

    // watchdog with MEM_TIMEOUT = 4
    do_reset();
    set_dwait(0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wd_err_low", {31'd0, mem_timeout_err}, 32'd0);
      @(posedge clk); #1;
    end
    cyc("wd_error_outs", c_frz);
    chk("wd_err_set", {31'd0, mem_timeout_err}, 32'd1);
    set_dwait(1);
    cyc("wd_error_sticky", c_frz);
    chk("wd_err_sticky", {31'd0, mem_timeout_err}, 32'd1);
    @(negedge clk);
    reset = 1;
    #1;
    chk("wd_async_reset_err", {31'd0, mem_timeout_err}, 32'd0);
    chk("wd_async_reset_outs", {24'd0, outs}, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    set_idle();
    cyc("wd_after_reset_run", c_idle);

    // halt, single step, step+resume
    do_reset();
    dbg_halt_req = 1;
    cyc("halt_req_cycle", c_idle);
    dbg_halt_req = 0;
    cyc("halted", c_halt);
    dbg_step = 1;
    cyc("step_pulse_halted", c_halt);
    dbg_step = 0;
    cyc("step_cycle", c_idle);
    cyc("step_rehalt", c_halt);
    dbg_step = 1; dbg_resume = 1;
    cyc("step_resume_pulse", c_halt);
    dbg_step = 0; dbg_resume = 0;
    cyc("resume_run", c_idle);
    cyc("resume_stays_run", c_idle);

    // halt request seen during MEM_WAIT
    do_reset();
    set_dwait(0);
    cyc("hp_enter_wait", c_frz);
    dbg_halt_req = 1;
    cyc("hp_wait_req", c_frz);
    dbg_halt_req = 0;
    set_dwait(1);
    cyc("hp_ready", c_idle);
    set_idle();
    cyc("hp_first_run", c_idle);
    cyc("hp_halted", c_halt);

    // step that hits a data wait returns to HALT
    dbg_step = 1;
    cyc("sw_pulse", c_halt);
    dbg_step = 0;
    set_dwait(0);
    cyc("sw_step_dwait", c_frz);
    set_dwait(1);
    cyc("sw_ready", c_idle);
    set_idle();
    cyc("sw_back_halt", c_halt);

    // counter saturation
    do_reset();
    id_rs1 = 5'd4; id_uses_rs1 = 1; ex_mem_read = 1; ex_rd = 5'd4;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
    end
    set_idle();
    chk("perf_load_use_sat", {28'd0, perf_load_use}, 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
